// File: rtl/osd_palette_fb.sv
// rtl/osd_palette_fb.sv - packed-pixel OSD framebuffer with palette lookup and background mixing
module osd_palette_fb #(
  parameter int ADDR_W  = 19,
  parameter int BPP     = 1,
  parameter int WORD_W  = 8,
  parameter int CW      = 10,
  localparam int PPW     = WORD_W / BPP,
  localparam int LOG_PPW = $clog2(PPW),
  localparam int WA_W    = ADDR_W - LOG_PPW
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] iPIX_ADDR,
  input  logic              iPIX_VALID,
  input  logic [1:0]        iMODE,
  input  logic [CW-1:0]     iBG_R,
  input  logic [CW-1:0]     iBG_G,
  input  logic [CW-1:0]     iBG_B,
  output logic [CW-1:0]     oRed,
  output logic [CW-1:0]     oGreen,
  output logic [CW-1:0]     oBlue,
  output logic              oVALID,
  input  logic [WA_W-1:0]   iWR_ADDR,
  input  logic [WORD_W-1:0] iWR_DATA,
  input  logic              iWR_EN,
  input  logic [BPP-1:0]    iPAL_ADDR,
  input  logic [CW-1:0]     iPAL_R,
  input  logic [CW-1:0]     iPAL_G,
  input  logic [CW-1:0]     iPAL_B,
  input  logic              iPAL_WE
);

  localparam int SLOT_W = (LOG_PPW > 0) ? LOG_PPW : 1;
  localparam int PAL_N  = 1 << BPP;

  logic [WORD_W-1:0] fbMem [0:(1<<WA_W)-1];
  logic [WORD_W-1:0] memQ;
  logic [WA_W-1:0]   rdWordAddr;
  logic [SLOT_W-1:0] rdSlot;

  logic [CW-1:0] palR [0:PAL_N-1];
  logic [CW-1:0] palG [0:PAL_N-1];
  logic [CW-1:0] palB [0:PAL_N-1];

  logic              s1Valid;
  logic [1:0]        s1Mode;
  logic [SLOT_W-1:0] s1Slot;
  logic [CW-1:0]     s1BgR, s1BgG, s1BgB;
  logic [BPP-1:0]    s1Idx;

  logic              s2Valid;
  logic [1:0]        s2Mode;
  logic [BPP-1:0]    s2Idx;
  logic [CW-1:0]     s2PalR, s2PalG, s2PalB;
  logic [CW-1:0]     s2BgR, s2BgG, s2BgB;

  logic [CW:0]       sumR, sumG, sumB;
  logic [CW-1:0]     mixR, mixG, mixB;

  assign rdWordAddr = iPIX_ADDR[ADDR_W-1:LOG_PPW];

  generate
    if (LOG_PPW > 0) begin : gSlot
      assign rdSlot = iPIX_ADDR[SLOT_W-1:0];
    end else begin : gNoSlot
      assign rdSlot = '0;
    end
  endgenerate

  // Framebuffer: synchronous write and read; a same-word read sees the pre-write contents
  always_ff @(posedge iCLK) begin
    if (iWR_EN) fbMem[iWR_ADDR] <= iWR_DATA;
    memQ <= fbMem[rdWordAddr];
  end

  // Stage 1: carry valid, mode, slot and background alongside the memory read
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1Valid <= 1'b0;
      s1Mode  <= '0;
      s1Slot  <= '0;
      s1BgR   <= '0;
      s1BgG   <= '0;
      s1BgB   <= '0;
    end else begin
      s1Valid <= iPIX_VALID;
      s1Mode  <= iMODE;
      s1Slot  <= rdSlot;
      s1BgR   <= iBG_R;
      s1BgG   <= iBG_G;
      s1BgB   <= iBG_B;
    end
  end

  // Pick this pixel's index out of the packed word; slot 0 sits in the MSBs
  always_comb begin
    s1Idx = '0;
    for (int k = 0; k < PPW; k++) begin
      if (s1Slot == SLOT_W'(k)) s1Idx = memQ[WORD_W-1-k*BPP -: BPP];
    end
  end

  // Palette: entry 0 resets to black, the rest to white; writes land on the edge
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < PAL_N; i++) begin
        if (i == 0) begin
          palR[i] <= '0;
          palG[i] <= '0;
          palB[i] <= '0;
        end else begin
          palR[i] <= '1;
          palG[i] <= '1;
          palB[i] <= '1;
        end
      end
    end else if (iPAL_WE) begin
      palR[iPAL_ADDR] <= iPAL_R;
      palG[iPAL_ADDR] <= iPAL_G;
      palB[iPAL_ADDR] <= iPAL_B;
    end
  end

  // Stage 2: registered palette lookup, so a same-edge palette write is not yet seen
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s2Valid <= 1'b0;
      s2Mode  <= '0;
      s2Idx   <= '0;
      s2PalR  <= '0;
      s2PalG  <= '0;
      s2PalB  <= '0;
      s2BgR   <= '0;
      s2BgG   <= '0;
      s2BgB   <= '0;
    end else begin
      s2Valid <= s1Valid;
      s2Mode  <= s1Mode;
      s2Idx   <= s1Idx;
      s2PalR  <= palR[s1Idx];
      s2PalG  <= palG[s1Idx];
      s2PalB  <= palB[s1Idx];
      s2BgR   <= s1BgR;
      s2BgG   <= s1BgG;
      s2BgB   <= s1BgB;
    end
  end

  assign sumR = {1'b0, s2PalR} + {1'b0, s2BgR};
  assign sumG = {1'b0, s2PalG} + {1'b0, s2BgG};
  assign sumB = {1'b0, s2PalB} + {1'b0, s2BgB};

  // Mix palette colour with the background according to the pixel's own mode
  always_comb begin
    mixR = s2PalR;
    mixG = s2PalG;
    mixB = s2PalB;
    case (s2Mode)
      2'd1: begin
        if (s2Idx == '0) begin
          mixR = s2BgR;
          mixG = s2BgG;
          mixB = s2BgB;
        end
      end
      2'd2: begin
        mixR = sumR[CW:1];
        mixG = sumG[CW:1];
        mixB = sumB[CW:1];
      end
      2'd3: begin
        mixR = s2BgR;
        mixG = s2BgG;
        mixB = s2BgB;
      end
      default: ;
    endcase
  end

  // Output stage: update colour only on valid pixels, otherwise hold
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oVALID <= 1'b0;
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
    end else begin
      oVALID <= s2Valid;
      if (s2Valid) begin
        oRed   <= mixR;
        oGreen <= mixG;
        oBlue  <= mixB;
      end
    end
  end

endmodule

// File: tb/tb_osd_palette_fb.sv
// tb/tb_osd_palette_fb.sv - directed vector bench for osd_palette_fb at BPP=1 and BPP=2
module tb_osd_palette_fb;
  localparam int AW = 12;
  localparam int CW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] pixAddr;
  logic [1:0]    mode;
  logic [CW-1:0] bgR, bgG, bgB, palR, palG, palB;
  logic          pixValid1, pixValid2, wrEn1, wrEn2, palWe1, palWe2;
  logic [8:0]    wrAddr1;
  logic [9:0]    wrAddr2;
  logic [7:0]    wrData1, wrData2;
  logic          palAddr1;
  logic [1:0]    palAddr2;
  logic [CW-1:0] r1, g1, b1, r2, g2, b2;
  logic          v1, v2;

  osd_palette_fb #(.ADDR_W(AW), .BPP(1), .WORD_W(8), .CW(CW)) u1 (
    .iCLK(clk), .iRST(rst), .iPIX_ADDR(pixAddr), .iPIX_VALID(pixValid1), .iMODE(mode),
    .iBG_R(bgR), .iBG_G(bgG), .iBG_B(bgB), .oRed(r1), .oGreen(g1), .oBlue(b1), .oVALID(v1),
    .iWR_ADDR(wrAddr1), .iWR_DATA(wrData1), .iWR_EN(wrEn1), .iPAL_ADDR(palAddr1),
    .iPAL_R(palR), .iPAL_G(palG), .iPAL_B(palB), .iPAL_WE(palWe1));

  osd_palette_fb #(.ADDR_W(AW), .BPP(2), .WORD_W(8), .CW(CW)) u2 (
    .iCLK(clk), .iRST(rst), .iPIX_ADDR(pixAddr), .iPIX_VALID(pixValid2), .iMODE(mode),
    .iBG_R(bgR), .iBG_G(bgG), .iBG_B(bgB), .oRed(r2), .oGreen(g2), .oBlue(b2), .oVALID(v2),
    .iWR_ADDR(wrAddr2), .iWR_DATA(wrData2), .iWR_EN(wrEn2), .iPAL_ADDR(palAddr2),
    .iPAL_R(palR), .iPAL_G(palG), .iPAL_B(palB), .iPAL_WE(palWe2));

  typedef struct {
    logic [CW-1:0] r, g, b;
    int            issue;
  } exp_t;

  typedef struct {
    bit            sel;
    int            addr, md, br, bg, bb, er, eg, eb;
  } vec_t;

  exp_t q1[$], q2[$];
  exp_t e1, e2;
  vec_t vecs[$];
  int   total = 0, bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void addv(bit sel, int addr, int md, int br, int bg, int bb,
                               int er, int eg, int eb);
    vec_t v;
    v.sel = sel; v.addr = addr; v.md = md;
    v.br = br; v.bg = bg; v.bb = bb; v.er = er; v.eg = eg; v.eb = eb;
    vecs.push_back(v);
  endfunction

  task automatic issue(input bit sel, input int addr, input int md, input int br, input int bg,
                       input int bb, input int er, input int eg, input int eb);
    exp_t e;
    pixAddr = AW'(addr);
    mode    = 2'(md);
    bgR = CW'(br); bgG = CW'(bg); bgB = CW'(bb);
    e.r = CW'(er); e.g = CW'(eg); e.b = CW'(eb); e.issue = cyc;
    pixValid1 = (sel == 1'b0);
    pixValid2 = (sel == 1'b1);
    if (sel == 1'b0) q1.push_back(e);
    else q2.push_back(e);
  endtask

  task automatic runVecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      issue(vecs[i].sel, vecs[i].addr, vecs[i].md, vecs[i].br, vecs[i].bg, vecs[i].bb,
            vecs[i].er, vecs[i].eg, vecs[i].eb);
      tick();
    end
    pixValid1 = 1'b0;
    pixValid2 = 1'b0;
    repeat (5) tick();
  endtask

  task automatic palWr(input bit sel, input int idx, input int r, input int g, input int b);
    palR = CW'(r); palG = CW'(g); palB = CW'(b);
    palAddr1 = 1'(idx);
    palAddr2 = 2'(idx);
    palWe1 = (sel == 1'b0);
    palWe2 = (sel == 1'b1);
    tick();
    palWe1 = 1'b0;
    palWe2 = 1'b0;
  endtask

  // Scoreboard: every valid output must match the oldest expectation, three cycles after issue
  always @(negedge clk) begin
    if (v1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected_valid actual=1 required=0");
      end else begin
        e1 = q1.pop_front();
        chk("dut1_pix", {r1, g1, b1}, {e1.r, e1.g, e1.b});
        chk("dut1_latency", cyc, e1.issue + 3);
      end
    end
    if (v2 === 1'b1) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL dut2_unexpected_valid actual=1 required=0");
      end else begin
        e2 = q2.pop_front();
        chk("dut2_pix", {r2, g2, b2}, {e2.r, e2.g, e2.b});
        chk("dut2_latency", cyc, e2.issue + 3);
      end
    end
  end

  initial begin
    // Phase A: BPP=1 word 0 = 0x80, pixels 0..7; BPP=2 word 5 = 0xE4, pixels 20..23
    for (int p = 0; p < 8; p++)
      addv(0, p, 0, p * 10, 3, 1000 - p, (p == 0) ? 1023 : 0, (p == 0) ? 1023 : 0, (p == 0) ? 1023 : 0);
    addv(1, 20, 0, 5, 5, 5, 0, 0, 300);
    addv(1, 21, 0, 6, 6, 6, 0, 200, 0);
    addv(1, 22, 0, 7, 7, 7, 100, 0, 0);
    addv(1, 23, 0, 8, 8, 8, 0, 0, 0);
    // Phase B: BPP=1 palette idx1 = (1023,512,0), mixing modes with per-pixel background
    addv(0, 0, 0, 1, 512, 1022, 1023, 512, 0);
    addv(0, 0, 2, 1, 512, 1022, 512, 512, 511);
    addv(0, 0, 3, 1, 512, 1022, 1, 512, 1022);
    addv(0, 1, 1, 1, 512, 1022, 1, 512, 1022);
    addv(0, 0, 1, 1, 512, 1022, 1023, 512, 0);
    addv(0, 0, 2, 1023, 1023, 1023, 1023, 767, 511);
    addv(0, 1, 2, 3, 5, 1023, 1, 2, 511);
    addv(0, 1, 0, 300, 301, 302, 0, 0, 0);
    addv(0, 0, 3, 7, 8, 9, 7, 8, 9);

    rst = 1'b1;
    pixAddr = '0; mode = '0; bgR = '0; bgG = '0; bgB = '0;
    palR = '0; palG = '0; palB = '0;
    pixValid1 = 1'b0; pixValid2 = 1'b0; wrEn1 = 1'b0; wrEn2 = 1'b0;
    palWe1 = 1'b0; palWe2 = 1'b0; wrAddr1 = '0; wrAddr2 = '0;
    wrData1 = '0; wrData2 = '0; palAddr1 = '0; palAddr2 = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_valid1", 32'(v1), 0);
    chk("reset_rgb1", {r1, g1, b1}, 0);
    chk("reset_valid2", 32'(v2), 0);
    chk("reset_rgb2", {r2, g2, b2}, 0);

    wrEn1 = 1'b1; wrAddr1 = 9'd0; wrData1 = 8'h80;
    wrEn2 = 1'b1; wrAddr2 = 10'd5; wrData2 = 8'hE4;
    tick();
    wrEn1 = 1'b0; wrEn2 = 1'b0;
    palWr(1, 0, 0, 0, 0);
    palWr(1, 1, 100, 0, 0);
    palWr(1, 2, 0, 200, 0);
    palWr(1, 3, 0, 0, 300);
    runVecs(0, 11);

    palWr(0, 1, 1023, 512, 0);
    runVecs(12, vecs.size() - 1);
    chk("hold_valid", 32'(v1), 0);
    chk("hold_rgb", {r1, g1, b1}, {10'd7, 10'd8, 10'd9});

    // Collision: same-cycle write of word 1 and read of pixel 8 returns the old word
    wrEn1 = 1'b1; wrAddr1 = 9'd1; wrData1 = 8'h00;
    tick();
    wrData1 = 8'hFF;
    issue(0, 8, 0, 0, 0, 0, 0, 0, 0);
    tick();
    wrEn1 = 1'b0;
    issue(0, 8, 0, 0, 0, 0, 1023, 512, 0);
    tick();
    pixValid1 = 1'b0;
    repeat (4) tick();

    // Palette write on the same edge as pixel 9's lookup; pixel 10 sees the new entry
    issue(0, 9, 0, 0, 0, 0, 1023, 512, 0);
    tick();
    palR = 10'd7; palG = 10'd7; palB = 10'd7; palAddr1 = 1'b1; palWe1 = 1'b1;
    issue(0, 10, 0, 0, 0, 0, 7, 7, 7);
    tick();
    palWe1 = 1'b0;
    pixValid1 = 1'b0;
    repeat (5) tick();

    // Mid-stream reset: ten back-to-back pixels, reset held from the fifth onward
    for (int i = 1; i <= 10; i++) begin
      if (i >= 5) rst = 1'b1;
      if (i <= 2) begin
        issue(0, 0, 0, 0, 0, 0, 7, 7, 7);
      end else begin
        pixAddr = '0; mode = '0; pixValid1 = 1'b1;
      end
      tick();
    end
    rst = 1'b0;
    pixValid1 = 1'b0;
    tick();
    chk("midreset_rgb", {r1, g1, b1}, 0);
    for (int i = 0; i < 3; i++) begin
      chk("midreset_valid", 32'(v1), 0);
      tick();
    end
    issue(0, 0, 0, 0, 0, 0, 1023, 1023, 1023);
    tick();
    issue(1, 21, 0, 0, 0, 0, 1023, 1023, 1023);
    tick();
    pixValid1 = 1'b0;
    pixValid2 = 1'b0;
    repeat (6) tick();

    chk("drain1", q1.size(), 0);
    chk("drain2", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
